// File: rtl/pc_stage_pkg.sv
// Shared types and constants for the instruction-fetch PC stage.
// Holds the FSM state encoding, the IF/ID payload struct and default parameter values.
package pc_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_INSN_DEFAULT = 32'h0000_006f;
  localparam logic [XLEN-1:0] NOP_INSN          = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // Payload carried through the IF/ID register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } ifid_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads on enable, drops the valid bit on flush.
// Flush has priority over enable; payload is kept on flush.
module if_id_reg
  import pc_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  logic  flush_i,
  input  ifid_t data_i,
  output logic  valid_o,
  output ifid_t data_o
);

  logic  valid_q, valid_d;
  ifid_t data_q,  data_d;

  // Next-state selection for the held instruction.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '{pc: '0, ir: NOP_INSN};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pc_stage.sv
// Fetch stage: PC generation, BOOT/RUN/HALT control, fetch counter and the IF/ID latch.
// Halt detection on HALT_INSN is built only when PC_STAGE_HALT_DETECT_EN is defined.
module pc_stage
  import pc_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_ir,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

`ifdef PC_STAGE_HALT_DETECT_EN
  localparam bit HaltDetectEn = 1'b1;
`else
  localparam bit HaltDetectEn = 1'b0;
`endif

  localparam logic [XLEN-1:0] BootPc = word_align(RESET_PC);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            halted_q, halted_d;

  logic            capture_c;
  logic            flush_c;
  logic            halt_hit_c;
  logic            ifid_valid_c;
  ifid_t           ifid_in_c;
  ifid_t           ifid_out_c;

  assign halt_hit_c = HaltDetectEn && (ir == HALT_INSN);

  // Next-state, PC, counter and IF/ID control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    capture_c = 1'b0;
    flush_c   = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = BootPc;
      end

      ST_RUN: begin
        if (redirect_valid) begin
          pc_d    = word_align(redirect_pc);
          flush_c = 1'b1;
        end else if (!ifid_valid_c || id_ready) begin
          capture_c = 1'b1;
          pc_d      = pc_q + PC_STEP;
          cnt_d     = cnt_q + XLEN'(1);
          if (halt_hit_c) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        // The halting instruction drains once decode takes it.
        halted_d = 1'b1;
        flush_c  = id_ready;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= BootPc;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign ifid_in_c.pc = pc_q;
  assign ifid_in_c.ir = ir;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .en_i    (capture_c),
    .flush_i (flush_c),
    .data_i  (ifid_in_c),
    .valid_o (ifid_valid_c),
    .data_o  (ifid_out_c)
  );

  assign pc        = pc_q;
  assign fetch_cnt = cnt_q;
  assign halted    = HaltDetectEn ? halted_q : 1'b0;
  assign id_valid  = ifid_valid_c;
  assign id_pc     = ifid_out_c.pc;
  assign id_ir     = ifid_out_c.ir;

endmodule

// File: tb/tb_pc_stage.sv
// Self-checking bench for pc_stage: directed scenarios plus randomized traffic
// against a cycle-level reference model; a second instance exercises PC wrap-around.
module tb_pc_stage;

`ifdef PC_STAGE_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HALT   = 32'h0000_006f;
  localparam logic [31:0] WRAPPC = 32'hFFFF_FFF8;

  typedef struct {
    int          ph;      // 0 boot, 1 run, 2 halt
    logic [31:0] pc;
    logic        valid;
    logic [31:0] idpc;
    logic [31:0] idir;
    logic        halted;
    logic [31:0] cnt;
  } mdl_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] ir, pc, id_pc, id_ir, fetch_cnt;
  logic        id_valid, halted;
  logic [31:0] ir_w, pc_w, id_pc_w, id_ir_w, fetch_cnt_w;
  logic        id_valid_w, halted_w;
  bit          halt_arm;
  int          total;
  int          bad;
  mdl_t        m0, m1;

  // Instruction memory content: pseudo-random words, HALT only at 0x20 when armed.
  function automatic logic [31:0] insn_at(input logic [31:0] a, input bit arm);
    logic [31:0] v;
    if (arm && a == 32'h0000_0020) return HALT;
    v = (a ^ 32'hA5A5_0000) * 32'h9E37_79B1;
    if (v == HALT) v = v ^ 32'h0000_0100;
    return v;
  endfunction

  always_comb ir   = insn_at(pc, halt_arm);
  always_comb ir_w = insn_at(pc_w, halt_arm);

  pc_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ir             (ir),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_ir          (id_ir),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt)
  );

  pc_stage #(.RESET_PC(WRAPPC)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc_w),
    .ir             (ir_w),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .id_ready       (1'b1),
    .id_valid       (id_valid_w),
    .id_pc          (id_pc_w),
    .id_ir          (id_ir_w),
    .halted         (halted_w),
    .fetch_cnt      (fetch_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of the behavioural model, written from the stage's rules.
  function automatic mdl_t model_step(input mdl_t m, input logic [31:0] rst_pc, input logic r,
                                      input logic rv, input logic [31:0] rpc, input logic rdy,
                                      input bit arm);
    mdl_t n = m;
    if (r) begin
      n.ph = 0; n.pc = rst_pc; n.valid = 1'b0; n.idpc = 32'h0;
      n.idir = NOP; n.halted = 1'b0; n.cnt = 32'h0;
    end else if (m.ph == 0) begin
      n.ph = 1;
    end else if (m.ph == 1) begin
      if (rv) begin
        n.pc = rpc & 32'hFFFF_FFFC;
        n.valid = 1'b0;
      end else if (!m.valid || rdy) begin
        n.idpc  = m.pc;
        n.idir  = insn_at(m.pc, arm);
        n.valid = 1'b1;
        n.pc    = m.pc + 32'd4;
        n.cnt   = m.cnt + 32'd1;
        if (HALT_EN && n.idir == HALT) begin
          n.ph = 2;
          n.halted = 1'b1;
        end
      end
    end else if (rdy) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic compare_all();
    check32("pc",        pc,          m0.pc);
    check32("id_valid",  32'(id_valid), 32'(m0.valid));
    check32("id_pc",     id_pc,       m0.idpc);
    check32("id_ir",     id_ir,       m0.idir);
    check32("halted",    32'(halted), 32'(m0.halted));
    check32("fetch_cnt", fetch_cnt,   m0.cnt);
    check32("w_pc",      pc_w,        m1.pc);
    check32("w_id_valid", 32'(id_valid_w), 32'(m1.valid));
    check32("w_id_pc",   id_pc_w,     m1.idpc);
    check32("w_id_ir",   id_ir_w,     m1.idir);
    check32("w_halted",  32'(halted_w), 32'(m1.halted));
    check32("w_fetch_cnt", fetch_cnt_w, m1.cnt);
  endtask

  // Drive one cycle of inputs, advance the models, then compare at the falling edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    m0 = model_step(m0, 32'h0, r, rv, rpc, rdy, halt_arm);
    m1 = model_step(m1, WRAPPC, r, 1'b0, 32'h0, 1'b1, halt_arm);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    total = 0; bad = 0; halt_arm = 1'b0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    m0 = '{ph: 0, pc: 32'h0, valid: 1'b0, idpc: 32'h0, idir: NOP, halted: 1'b0, cnt: 32'h0};
    m1 = '{ph: 0, pc: WRAPPC, valid: 1'b0, idpc: 32'h0, idir: NOP, halted: 1'b0, cnt: 32'h0};

    // Reset values.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check32("rst_pc", pc, 32'h0);
    check32("rst_id_ir", id_ir, NOP);
    check32("rst_cnt", fetch_cnt, 32'h0);
    check32("rst_wrap_pc", pc_w, WRAPPC);

    // Boot cycle, then streaming captures with wrap on the second instance.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check32("boot_valid", 32'(id_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check32("seq_id_pc", id_pc, 32'(4 * i));
      check32("wrap_id_pc", id_pc_w, WRAPPC + 32'(4 * i));
    end

    // Stall three cycles holding id_pc = 8.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check32("stall_id_pc", id_pc, 32'h8);
      check32("stall_id_ir", id_ir, insn_at(32'h8, 1'b0));
      check32("stall_pc", pc, 32'hC);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check32("resume_id_pc", id_pc, 32'hC);
    check32("cnt4", fetch_cnt, 32'h4);

    // Redirect during a stall.
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check32("redir_valid", 32'(id_valid), 32'h0);
    check32("redir_pc", pc, 32'h100);
    check32("redir_cnt", fetch_cnt, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check32("redir_id_pc", id_pc, 32'h100);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0), $urandom, 1'($urandom));
    end

    // Halt instruction at 0x20.
    halt_arm = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check32("halt_id_ir", id_ir, HALT);
    check32("halt_id_pc", id_pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, ($urandom_range(1) == 0), 32'h0000_0200, 1'b1);
      if (HALT_EN) begin
        check32("halted", 32'(halted), 32'h1);
        check32("halt_pc", pc, 32'h24);
      end else begin
        check32("nohalt", 32'(halted), 32'h0);
      end
    end

    // Reset while halted.
    cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    check32("rst_halted", 32'(halted), 32'h0);
    check32("rst_halt_pc", pc, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    check32("boot_pc", pc, 32'h0);
    check32("boot_id_valid", 32'(id_valid), 32'h0);

    // Redirect coincident with the halt instruction wins.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check32("pre_pc", pc, 32'h20);
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    check32("race_pc", pc, 32'h40);
    check32("race_halted", 32'(halted), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check32("race_run_pc", pc, 32'h4C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
